// File: rtl/vai_rx_demux.sv
// vai_rx_demux: registered CCI-P Rx demux; memory responses steered by the mdata AFU tag, MMIO by address window.
// c0 header is the 28-bit CCI-P union: mdata = hdr[15:0] for responses, MMIO address = hdr[27:12].
module vai_rx_demux #(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int TAG_LSB       = 12,
  parameter int TAG_W         = 4,
  parameter int MMIO_WIN_BITS = 12,
  parameter int DATA_W        = 512
) (
  input  logic                    i_pclk,
  input  logic                    i_soft_reset_n,
  input  logic                    i_c0_rsp_valid,
  input  logic                    i_c0_mmio_rd_valid,
  input  logic                    i_c0_mmio_wr_valid,
  input  logic [27:0]             i_c0_hdr,
  input  logic [DATA_W-1:0]       i_c0_data,
  input  logic                    i_c1_rsp_valid,
  input  logic [27:0]             i_c1_hdr,
  input  logic                    i_c0_tx_alm_full,
  input  logic                    i_c1_tx_alm_full,
  output logic [NUM_SUB_AFUS-1:0] o_afu_c0_rsp_valid,
  output logic [NUM_SUB_AFUS-1:0] o_afu_c0_mmio_rd_valid,
  output logic [NUM_SUB_AFUS-1:0] o_afu_c0_mmio_wr_valid,
  output logic [NUM_SUB_AFUS-1:0] o_afu_c1_rsp_valid,
  output logic [27:0]             o_afu_c0_hdr,
  output logic                    o_mgr_c0_rsp_valid,
  output logic                    o_mgr_c0_mmio_rd_valid,
  output logic                    o_mgr_c0_mmio_wr_valid,
  output logic                    o_mgr_c1_rsp_valid,
  output logic [27:0]             o_mgr_c0_hdr,
  output logic [DATA_W-1:0]       o_c0_data,
  output logic [27:0]             o_c1_hdr,
  output logic                    o_c0_tx_alm_full,
  output logic                    o_c1_tx_alm_full,
  output logic [15:0]             o_drop_cnt,
  output logic                    o_tag_err
);
  localparam int WW = 16 - MMIO_WIN_BITS;
  localparam logic [27:0] TAG_MASK = 28'(((1 << TAG_W) - 1) << TAG_LSB);
  localparam logic [27:0] WIN_MASK = 28'(((1 << WW) - 1) << (12 + MMIO_WIN_BITS));
  logic [TAG_W-1:0] w_c0_tag, w_c1_tag;
  logic [WW-1:0] w_win;
  logic w_win_bad, w_mmio_ok, w_c0_drop, w_mmio_drop, w_c1_drop;
  logic [1:0] w_drops;
  logic [16:0] w_sum;
  logic [27:0] w_c0_hdr_tagclr;
  logic [NUM_SUB_AFUS-1:0] w_afu_rsp0, w_afu_rd, w_afu_wr, w_afu_rsp1;
  logic w_mgr_rsp0, w_mgr_rd, w_mgr_wr, w_mgr_rsp1;
  logic [NUM_SUB_AFUS-1:0] r_afu_rsp0, r_afu_rd, r_afu_wr, r_afu_rsp1;
  logic r_mgr_rsp0, r_mgr_rd, r_mgr_wr, r_mgr_rsp1;
  logic [27:0] r_afu_hdr0, r_mgr_hdr0, r_hdr1;
  logic [DATA_W-1:0] r_data0;
  logic r_c0_alm, r_c1_alm, r_rst_done, r_tag_err;
  logic [15:0] r_drop_cnt;

  assign w_c0_tag = i_c0_hdr[TAG_LSB +: TAG_W];
  assign w_c1_tag = i_c1_hdr[TAG_LSB +: TAG_W];
  assign w_win = i_c0_hdr[27 -: WW];
  assign w_win_bad = w_win > WW'(NUM_SUB_AFUS);
  // A response owns c0 outright; any MMIO valid alongside it is discarded.
  assign w_mmio_ok = !i_c0_rsp_valid;
  assign w_c0_drop = i_c0_rsp_valid && w_c0_tag > TAG_W'(NUM_SUB_AFUS);
  assign w_c1_drop = i_c1_rsp_valid && w_c1_tag > TAG_W'(NUM_SUB_AFUS);
  assign w_mmio_drop = (i_c0_mmio_rd_valid || i_c0_mmio_wr_valid) &&
                       (i_c0_rsp_valid || (i_c0_mmio_wr_valid && w_win_bad));
  assign w_drops = {1'b0, w_c0_drop} + {1'b0, w_mmio_drop} + {1'b0, w_c1_drop};
  assign w_sum = {1'b0, r_drop_cnt} + {15'b0, w_drops};
  assign w_c0_hdr_tagclr = i_c0_hdr & ~TAG_MASK;
  assign w_mgr_rsp0 = i_c0_rsp_valid && w_c0_tag == TAG_W'(NUM_SUB_AFUS);
  assign w_mgr_rsp1 = i_c1_rsp_valid && w_c1_tag == TAG_W'(NUM_SUB_AFUS);
  // Out-of-range reads still go to the manager so the host always gets a completion.
  assign w_mgr_rd = w_mmio_ok && i_c0_mmio_rd_valid && (w_win == '0 || w_win_bad);
  assign w_mgr_wr = w_mmio_ok && i_c0_mmio_wr_valid && w_win == '0;

  always_comb begin
    w_afu_rsp0 = '0;
    w_afu_rd = '0;
    w_afu_wr = '0;
    w_afu_rsp1 = '0;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      w_afu_rsp0[i] = i_c0_rsp_valid && w_c0_tag == TAG_W'(i);
      w_afu_rd[i] = w_mmio_ok && i_c0_mmio_rd_valid && w_win == WW'(i + 1);
      w_afu_wr[i] = w_mmio_ok && i_c0_mmio_wr_valid && w_win == WW'(i + 1);
      w_afu_rsp1[i] = i_c1_rsp_valid && w_c1_tag == TAG_W'(i);
    end
  end

  always_ff @(posedge i_pclk or negedge i_soft_reset_n) begin
    if (!i_soft_reset_n) begin
      {r_afu_rsp0, r_afu_rd, r_afu_wr, r_afu_rsp1} <= '0;
      {r_mgr_rsp0, r_mgr_rd, r_mgr_wr, r_mgr_rsp1} <= '0;
      {r_c0_alm, r_c1_alm} <= 2'b11;
      r_rst_done <= 1'b0;
      r_drop_cnt <= '0;
      r_tag_err <= 1'b0;
    end else begin
      {r_afu_rsp0, r_afu_rd, r_afu_wr, r_afu_rsp1} <= {w_afu_rsp0, w_afu_rd, w_afu_wr, w_afu_rsp1};
      {r_mgr_rsp0, r_mgr_rd, r_mgr_wr, r_mgr_rsp1} <= {w_mgr_rsp0, w_mgr_rd, w_mgr_wr, w_mgr_rsp1};
      // Tx stays blocked for one extra edge after reset release.
      r_rst_done <= 1'b1;
      r_c0_alm <= r_rst_done ? i_c0_tx_alm_full : 1'b1;
      r_c1_alm <= r_rst_done ? i_c1_tx_alm_full : 1'b1;
      r_drop_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      r_tag_err <= r_tag_err || w_drops != 2'd0;
    end
  end

  always_ff @(posedge i_pclk) begin
    r_afu_hdr0 <= i_c0_rsp_valid ? w_c0_hdr_tagclr : i_c0_hdr & ~WIN_MASK;
    r_mgr_hdr0 <= i_c0_rsp_valid ? w_c0_hdr_tagclr : i_c0_hdr;
    r_hdr1 <= i_c1_hdr & ~TAG_MASK;
    r_data0 <= i_c0_data;
  end

  assign o_afu_c0_rsp_valid = r_afu_rsp0;
  assign o_afu_c0_mmio_rd_valid = r_afu_rd;
  assign o_afu_c0_mmio_wr_valid = r_afu_wr;
  assign o_afu_c1_rsp_valid = r_afu_rsp1;
  assign o_afu_c0_hdr = r_afu_hdr0;
  assign o_mgr_c0_rsp_valid = r_mgr_rsp0;
  assign o_mgr_c0_mmio_rd_valid = r_mgr_rd;
  assign o_mgr_c0_mmio_wr_valid = r_mgr_wr;
  assign o_mgr_c1_rsp_valid = r_mgr_rsp1;
  assign o_mgr_c0_hdr = r_mgr_hdr0;
  assign o_c0_data = r_data0;
  assign o_c1_hdr = r_hdr1;
  assign o_c0_tx_alm_full = r_c0_alm;
  assign o_c1_tx_alm_full = r_c1_alm;
  assign o_drop_cnt = r_drop_cnt;
  assign o_tag_err = r_tag_err;
endmodule
